// File: rtl/pe_pkg.sv
// Shared types, default sizes and saturating-add helpers for the processing-element family.
package pe_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ACC_W_DEF  = 20;
  localparam int K_MAX_DEF  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } pe_state_t;

  // Unsigned add clamped to [0, 2^w-1]; bit 64 of the result flags a clamp. Valid for w <= 63.
  function automatic logic [64:0] sat_add_u(input logic [63:0] a, input logic [63:0] b, input int w);
    logic [64:0] sum;
    logic [64:0] max;
    sum = {1'b0, a} + {1'b0, b};
    max = (65'd1 << w) - 65'd1;
    if (sum > max) begin
      sat_add_u = {1'b1, max[63:0]};
    end else begin
      sat_add_u = {1'b0, sum[63:0]};
    end
  endfunction

  // Signed add clamped to [-2^(w-1), 2^(w-1)-1]; operands arrive sign-extended to 64 bits.
  function automatic logic [64:0] sat_add_s(input logic [63:0] a, input logic [63:0] b, input int w);
    logic signed [64:0] sum;
    logic signed [64:0] hi;
    logic signed [64:0] lo;
    sum = $signed({a[63], a}) + $signed({b[63], b});
    hi  = (65'sd1 <<< (w - 1)) - 65'sd1;
    lo  = -(65'sd1 <<< (w - 1));
    if (sum > hi) begin
      sat_add_s = {1'b1, hi[63:0]};
    end else if (sum < lo) begin
      sat_add_s = {1'b1, lo[63:0]};
    end else begin
      sat_add_s = {1'b0, sum[63:0]};
    end
  endfunction

endpackage

// File: rtl/pe_os_mac_if.sv
// Operand/result bus of one processing element: west/north operands in, east/south forwards and result out.
interface pe_os_mac_if
  import pe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
);
  logic              in_valid;
  logic [DATA_W-1:0] a_in;
  logic [DATA_W-1:0] b_in;
  logic [DATA_W-1:0] a_out;
  logic [DATA_W-1:0] b_out;
  logic              out_valid;
  logic [ACC_W-1:0]  acc_out;
  logic              done;
  logic              ovf;

  modport master (
    output in_valid, a_in, b_in,
    input  a_out, b_out, out_valid, acc_out, done, ovf
  );

  modport slave (
    input  in_valid, a_in, b_in,
    output a_out, b_out, out_valid, acc_out, done, ovf
  );
endinterface

// File: rtl/pe_mul_ext.sv
// Combinational DATA_W x DATA_W multiply, sign- or zero-extended to the accumulator width.
module pe_mul_ext
  import pe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              signed_mode,
  output logic [ACC_W-1:0]  prod
);
  localparam int PW = 2 * DATA_W;

  logic signed [PW-1:0] a_sx_s;
  logic signed [PW-1:0] b_sx_s;
  logic signed [PW-1:0] prod_sgn_s;
  logic        [PW-1:0] a_zx_s;
  logic        [PW-1:0] b_zx_s;
  logic        [PW-1:0] prod_uns_s;

  // Operands are widened first so the product keeps every bit in either mode.
  assign a_sx_s     = PW'($signed(a));
  assign b_sx_s     = PW'($signed(b));
  assign prod_sgn_s = a_sx_s * b_sx_s;
  assign a_zx_s     = PW'(a);
  assign b_zx_s     = PW'(b);
  assign prod_uns_s = a_zx_s * b_zx_s;

  // Select signed or unsigned product and extend it to the accumulator width
  always_comb begin
    prod = '0;
    if (signed_mode) begin
      prod = ACC_W'(prod_sgn_s);
    end else begin
      prod = ACC_W'(prod_uns_s);
    end
  end
endmodule

// File: rtl/pe_os_mac.sv
// Output-stationary systolic MAC cell with valid handshake and programmable tile length.
// Optional macro PE_SAT_EN: saturating accumulation with sticky ovf; otherwise wrap and ovf tied 0.
module pe_os_mac
  import pe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int K_MAX  = K_MAX_DEF,
  localparam int CNT_W = $clog2(K_MAX + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             signed_mode,
  input  logic [CNT_W-1:0] k_len,
  pe_os_mac_if.slave       bus
);

  pe_state_t         state_r;
  logic [ACC_W-1:0]  acc_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  k_lat_r;
  logic              mode_lat_r;
  logic              done_r;
  logic              ovf_r;
  logic [DATA_W-1:0] a_r;
  logic [DATA_W-1:0] b_r;
  logic              v_r;

  logic              first_beat_s;
  logic              mode_s;
  logic [ACC_W-1:0]  prod_s;
  logic [ACC_W-1:0]  sum_s;
  logic              clamp_s;
  logic [CNT_W-1:0]  k_eff_s;
  logic [CNT_W-1:0]  cnt_inc_s;

  // A beat outside ACC opens a new tile and must use the live mode, not the stale latch.
  assign first_beat_s = bus.in_valid && (state_r != ACC);
  assign mode_s       = first_beat_s ? signed_mode : mode_lat_r;
  assign cnt_inc_s    = cnt_r + CNT_W'(1'b1);

  pe_mul_ext #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mul (
    .a           (bus.a_in),
    .b           (bus.b_in),
    .signed_mode (mode_s),
    .prod        (prod_s)
  );

  // Effective tile length: zero means one beat, oversize requests clamp to K_MAX
  always_comb begin
    k_eff_s = k_len;
    if (k_len == CNT_W'(1'b0)) begin
      k_eff_s = CNT_W'(1'b1);
    end else if (k_len > CNT_W'(K_MAX)) begin
      k_eff_s = CNT_W'(K_MAX);
    end else begin
      k_eff_s = k_len;
    end
  end

`ifdef PE_SAT_EN
  logic [64:0] sat_res_s;
  logic        sat_unused_s;

  // Saturating accumulate using the mode latched at the tile's first beat
  always_comb begin
    sat_res_s = 65'd0;
    if (mode_lat_r) begin
      sat_res_s = sat_add_s(64'($signed(acc_r)), 64'($signed(prod_s)), ACC_W);
    end else begin
      sat_res_s = sat_add_u(64'(acc_r), 64'(prod_s), ACC_W);
    end
    sum_s   = sat_res_s[ACC_W-1:0];
    clamp_s = sat_res_s[64];
  end

  assign sat_unused_s = ^sat_res_s[63:ACC_W];
`else
  // Plain modulo-2^ACC_W accumulate
  always_comb begin
    sum_s   = acc_r + prod_s;
    clamp_s = 1'b0;
  end
`endif

  // Tile FSM, accumulator, beat counter and neighbour forwarding registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      acc_r      <= '0;
      cnt_r      <= '0;
      k_lat_r    <= '0;
      mode_lat_r <= 1'b0;
      done_r     <= 1'b0;
      ovf_r      <= 1'b0;
      a_r        <= '0;
      b_r        <= '0;
      v_r        <= 1'b0;
    end else if (clear) begin
      state_r    <= IDLE;
      acc_r      <= '0;
      cnt_r      <= '0;
      k_lat_r    <= '0;
      mode_lat_r <= 1'b0;
      done_r     <= 1'b0;
      ovf_r      <= 1'b0;
      a_r        <= '0;
      b_r        <= '0;
      v_r        <= 1'b0;
    end else begin
      a_r <= bus.a_in;
      b_r <= bus.b_in;
      v_r <= bus.in_valid;
      case (state_r)
        IDLE, DONE: begin
          if (bus.in_valid) begin
            acc_r      <= prod_s;
            cnt_r      <= CNT_W'(1'b1);
            k_lat_r    <= k_eff_s;
            mode_lat_r <= signed_mode;
            ovf_r      <= 1'b0;
            if (k_eff_s == CNT_W'(1'b1)) begin
              state_r <= DONE;
              done_r  <= 1'b1;
            end else begin
              state_r <= ACC;
              done_r  <= 1'b0;
            end
          end
        end
        ACC: begin
          if (bus.in_valid) begin
            acc_r <= sum_s;
            cnt_r <= cnt_inc_s;
            ovf_r <= ovf_r | clamp_s;
            if (cnt_inc_s == k_lat_r) begin
              state_r <= DONE;
              done_r  <= 1'b1;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.a_out     = a_r;
  assign bus.b_out     = b_r;
  assign bus.out_valid = v_r;
  assign bus.acc_out   = acc_r;
  assign bus.done      = done_r;
  assign bus.ovf       = ovf_r;

endmodule

// File: doc/pe_os_mac.md
Name: pe_os_mac

Overview:
Output-stationary systolic processing element that succeeds the basic 8-bit wrap-around PE. It adds parametrised data and accumulator widths, a valid handshake, signed/unsigned mode, and a programmable dot-product length with a done flag. Operands flow east (a) and south (b) through registers with their valid bit. Each PE instance is one cell of the N×N array; the array controller reads acc_out when done is high.

Parameters:
DATA_W, 8, operand width (a, b)
ACC_W, 20, accumulator width; must be ≥ 2*DATA_W
K_MAX, 16, maximum dot-product length; CNT_W = $clog2(K_MAX+1)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
clear  in  1  synchronous clear of accumulator, counter, FSM and forwarding registers
signed_mode  in  1  1 = two's-complement operands, 0 = unsigned; sampled on the first beat of a tile
k_len  in  CNT_W  number of valid beats per tile; sampled on the first beat
in_valid  in  1  a_in/b_in are valid this cycle
a_in  in  DATA_W  west operand
b_in  in  DATA_W  north operand
a_out  out  DATA_W  registered a_in, to east neighbour
b_out  out  DATA_W  registered b_in, to south neighbour
out_valid  out  1  registered in_valid, to neighbours
acc_out  out  ACC_W  accumulator value
done  out  1  acc_out holds a complete tile result
ovf  out  1  sticky overflow flag; tied 0 unless PE_SAT_EN is defined

Behaviour:
- Reset (rst_n=0, asynchronous): all outputs, acc, cnt, k_lat, mode_lat = 0; FSM = IDLE.
- Forwarding: a_out, b_out and out_valid each register their input every cycle, so latency is 1. a_out/b_out update regardless of in_valid. clear forces all three to 0.
- Product: DATA_W×DATA_W multiply, sign- or zero-extended to ACC_W according to mode_lat. Without PE_SAT_EN the sum wraps modulo 2^ACC_W.
- FSM states: IDLE, ACC, DONE.
  - IDLE, in_valid=1: acc<=prod; cnt<=1; latch k_len and signed_mode. If the effective k is 1, go to DONE; otherwise go to ACC.
  - ACC, in_valid=1: acc<=acc+prod; cnt<=cnt+1. When cnt+1==k_lat, go to DONE.
  - ACC, in_valid=0: hold all state (bubbles are allowed).
  - DONE: done=1 and acc_out is stable. in_valid=1 starts a new tile exactly as from IDLE (acc<=prod, not accumulated), so back-to-back tiles need no gap. done drops in the same edge.
  - DONE, in_valid=0: hold.
- k_len==0 is treated as 1. k_len>K_MAX is clamped to K_MAX.
- done rises on the clock edge that registers the k-th beat. The result is visible one cycle after the last operand is applied.
- acc_out always equals acc, including mid-tile partial sums.
- clear has priority over in_valid on the same edge: the beat is dropped, state goes to IDLE, ovf=0.
- Changes to k_len or signed_mode mid-tile are ignored until the next first beat.

Optional Feature:
PE_SAT_EN
- Defined: accumulation saturates instead of wrapping.
  - Signed mode: result clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - Unsigned mode: result clamps to [0, 2^ACC_W-1].
  - ovf sets on any clamp and stays set until clear, reset, or the first beat of the next tile.
- Undefined: modulo-2^ACC_W wrap; ovf is constant 0.

Decomposition:
- Package pe_pkg:
  - pe_state_t enum (IDLE/ACC/DONE)
  - default DATA_W/ACC_W/K_MAX localparams
  - sat_add function, signed and unsigned variants
- One sub-module, pe_mul_ext: combinational multiply plus sign/zero extension to ACC_W, shared with the future weight-stationary PE.
- FSM, counter and forwarding registers stay in pe_os_mac.

Test Plan:
1. Unsigned baseline: ACC_W=20, k_len=9, pairs (1,9),(2,8),(3,7),(4,3),(5,2),(6,1),(7,8),(8,9),(9,2) on consecutive cycles -> acc_out=220, done=1 one cycle after the 9th beat, ovf=0.
2. Signed mode: k_len=2, (0xFD,5),(2,3) -> acc_out = -9 = 0xFFFF7 (ACC_W=20).
3. Bubbles and back-to-back tiles: k_len=3, beats (1,1),gap,(2,2),gap,(3,3) -> done with acc_out=14. Then the next beat (4,4) in DONE -> done=0, acc_out=16 with no carry-over.
4. Forwarding: any stream -> a_out/b_out/out_valid equal the previous cycle's inputs. clear pulse -> all three 0 next cycle.
5. Overflow, ACC_W=16, unsigned, k_len=2, (255,255)×2 -> without PE_SAT_EN acc_out=64514, ovf=0; with it acc_out=65535, ovf=1.
6. Abort: rst_n low for 3 cycles, then clear mid-tile at beat 4 of k_len=8 -> acc_out=0, done=0, FSM IDLE. A fresh tile then completes correctly.
